// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, divide-by-zero flagged in a single cycle.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // The dividend shifts out of shift_q's MSB while quotient bits shift in at the LSB.
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        partial  = {rem_q, shift_q[WIDTH-1]};
        trial    = partial - {1'b0, divisor_q};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        divisor_d = divisor;
                        shift_d   = dividend;
                        rem_d     = '0;
                        count_d   = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d   = rem_next;
                shift_d = {shift_q[WIDTH-2:0], q_bit};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    quotient_d  = {shift_q[WIDTH-2:0], q_bit};
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: WIDTH=4 directed/exhaustive and WIDTH=8 random,
// expected results queued at issue time and checked by per-instance monitors on done.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] dividend4 = '0, divisor4 = '0;
    logic       busy4, done4, dbz4;
    logic [3:0] quotient4, remainder4;

    logic       start8 = 1'b0;
    logic [7:0] dividend8 = '0, divisor8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] quotient8, remainder8;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(4)) u_div4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dividend4), .divisor(divisor4),
        .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
        .div_by_zero(dbz4)
    );

    seq_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per done cycle; a done with nothing queued is an error.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && done4) begin
            if (sb4.size() == 0) begin
                check("w4_unexpected_done", 1, 0);
            end else begin
                e = sb4.pop_front();
                check("w4_quotient", int'(quotient4), e.q);
                check("w4_remainder", int'(remainder4), e.r);
                check("w4_div_by_zero", int'(dbz4), e.dbz);
                check("w4_busy_at_done", int'(busy4), 1);
                check("w4_latency_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_done", 1, 0);
            end else begin
                e = sb8.pop_front();
                check("w8_quotient", int'(quotient8), e.q);
                check("w8_remainder", int'(remainder8), e.r);
                check("w8_div_by_zero", int'(dbz8), e.dbz);
                check("w8_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one operation at a negedge once the selected instance is idle; returns one
    // negedge after the accepting edge with start already low.
    task automatic run_op(input int w, input int a, input int b,
                          input int eq, input int er, input int edbz);
        int   n = 0;
        exp_t e;
        while ((w == 4) ? busy4 : busy8) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("wait_idle_timeout", n, 0);
                return;
            end
        end
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.cyc = cyc + ((b == 0) ? 1 : w + 1);
        if (w == 4) begin
            start4 = 1'b1; dividend4 = 4'(a); divisor4 = 4'(b);
            sb4.push_back(e);
        end else begin
            start8 = 1'b1; dividend8 = 8'(a); divisor8 = 8'(b);
            sb8.push_back(e);
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic run_ref(input int w, input int a, input int b);
        int mask = (1 << w) - 1;
        if (b == 0) run_op(w, a, b, mask, a, 1);
        else        run_op(w, a, b, a / b, a % b, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy4 || busy8 || sb4.size() != 0 || sb8.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                check("drain_timeout", n, 0);
                return;
            end
        end
    endtask

    // Directed vectors: dividend, divisor, quotient, remainder, div_by_zero (hand-computed).
    int dir_tab[8][5] = '{
        '{13,  3,  4, 1, 0},
        '{15,  1, 15, 0, 0},
        '{ 0,  7,  0, 0, 0},
        '{ 5,  9,  0, 5, 0},
        '{15, 15,  1, 0, 0},
        '{ 9,  0, 15, 9, 1},
        '{ 8,  2,  4, 0, 0},
        '{ 0,  0, 15, 0, 1}
    };

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_quotient", int'(quotient4), 0);
        check("rst_remainder", int'(remainder4), 0);
        check("rst_div_by_zero", int'(dbz4), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (dir_tab[i])
            run_op(4, dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3], dir_tab[i][4]);

        // Start pulsed in RUN with other operands must be ignored: single done, 11/2 result.
        run_op(4, 11, 2, 5, 1, 0);
        start4 = 1'b1; dividend4 = 4'd14; divisor4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        drain(50);
        check("w4_hold_quotient", int'(quotient4), 5);
        check("w4_hold_remainder", int'(remainder4), 1);

        // Reset in the second RUN cycle aborts with no done pulse and clears outputs.
        run_op(4, 13, 3, 4, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        sb4.delete();
        @(negedge clk);
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        check("abort_quotient", int'(quotient4), 0);
        check("abort_remainder", int'(remainder4), 0);
        check("abort_div_by_zero", int'(dbz4), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_ref(4, a, b);
        drain(50);

        run_ref(8, 255, 1);
        run_ref(8, 200, 0);
        run_ref(8, 254, 255);
        for (int k = 0; k < 40; k++)
            run_ref(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        drain(100);

        check("w4_pending_at_end", sb4.size(), 0);
        check("w8_pending_at_end", sb8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
